// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem read request and IF/ID latch.
// Optional one-entry fetch buffer enabled with `define FETCH_BUF_EN.
module fetch_stage #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              pc_en,
  input  logic              ifid_en,
  input  logic              flush_ifid,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic              fetch_halted
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_BUFFERED = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
    logic              valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: '0, pc4: '0, valid: 1'b0};

  state_t            r_state, w_state_next;
  logic [WORD_W-1:0] r_pc, w_pc_next;
  ifid_t             r_ifid, w_ifid_next;
  logic              w_commit;
  logic              w_redir;
  logic [WORD_W-1:0] w_pc4;
  logic [WORD_W-1:0] w_redir_pc;

  assign w_commit   = (r_state == S_FETCH) && ihit && !redirect;
  assign w_redir    = redirect && pc_en;
  assign w_pc4      = r_pc + WORD_W'(4);
  assign w_redir_pc = redirect_pc & ~WORD_W'(3);

  assign imemaddr     = r_pc;
  assign imemREN      = (r_state == S_FETCH);
  assign fetch_halted = (r_state == S_HALTED);
  assign ifid_instr   = r_ifid.instr;
  assign ifid_pc4     = r_ifid.pc4;
  assign ifid_valid   = r_ifid.valid;

`ifdef FETCH_BUF_EN
  // valid field doubles as buf_full
  ifid_t r_buf, w_buf_next;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ifid_next  = r_ifid;
    w_buf_next   = r_buf;

    case (r_state)
      S_IDLE:     w_state_next = S_FETCH;
      S_FETCH:    if (w_commit && !ifid_en && !flush_ifid) w_state_next = S_BUFFERED;
      S_BUFFERED: if (w_redir || flush_ifid || ifid_en) w_state_next = S_FETCH;
      S_HALTED:   w_state_next = S_HALTED;
      default:    w_state_next = S_IDLE;
    endcase
    if (halt) w_state_next = S_HALTED;

    // pc_en gates only redirects; every commit advances the PC
    if (!halt && r_state != S_HALTED) begin
      if (w_redir)       w_pc_next = w_redir_pc;
      else if (w_commit) w_pc_next = w_pc4;
    end

    if (halt || flush_ifid) begin
      w_ifid_next = BUBBLE;
    end else if (ifid_en) begin
      if (r_state == S_BUFFERED && !w_redir)
        w_ifid_next = r_buf;
      else if (w_commit)
        w_ifid_next = '{instr: imemload, pc4: w_pc4, valid: 1'b1};
      else
        w_ifid_next = BUBBLE;
    end

    if (halt || flush_ifid || w_redir)
      w_buf_next = BUBBLE;
    else if (w_commit && !ifid_en)
      w_buf_next = '{instr: imemload, pc4: w_pc4, valid: 1'b1};
    else if (r_state == S_BUFFERED && ifid_en)
      w_buf_next = BUBBLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_buf <= BUBBLE;
    else     r_buf <= w_buf_next;
  end
`else
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ifid_next  = r_ifid;

    case (r_state)
      S_IDLE:   w_state_next = S_FETCH;
      S_FETCH:  w_state_next = S_FETCH;
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_IDLE;
    endcase
    if (halt) w_state_next = S_HALTED;

    // a commit with pc_en low is dropped and refetched from the same PC
    if (!halt && r_state != S_HALTED) begin
      if (w_redir)                w_pc_next = w_redir_pc;
      else if (w_commit && pc_en) w_pc_next = w_pc4;
    end

    if (halt || flush_ifid)
      w_ifid_next = BUBBLE;
    else if (ifid_en && w_commit)
      w_ifid_next = '{instr: imemload, pc4: w_pc4, valid: 1'b1};
    else if (ifid_en)
      w_ifid_next = BUBBLE;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_pc    <= PC_INIT;
      r_ifid  <= BUBBLE;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ifid  <= w_ifid_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; buffer scenario runs when
// FETCH_BUF_EN is defined.
module tb_fetch_stage;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        pc_en = 1'b0;
  logic        ifid_en = 1'b0;
  logic        flush_ifid = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_halted;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.WORD_W(32), .PC_INIT(32'h0)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .pc_en(pc_en), .ifid_en(ifid_en), .flush_ifid(flush_ifid),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .fetch_halted(fetch_halted)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; ihit = 1'b1; imemload = 32'h2001_0005; pc_en = 1'b1; ifid_en = 1'b1;
    tick(); tick();
    total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", imemaddr, 32'h0); end
    total++; if (imemREN !== 1'b0) begin bad++; $display("FAIL rst_ren got=%b exp=0", imemREN); end
    total++; if ({ifid_instr, ifid_pc4, ifid_valid} !== 65'h0) begin bad++; $display("FAIL rst_ifid got=%h/%h/%b exp=0", ifid_instr, ifid_pc4, ifid_valid); end
    total++; if (fetch_halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", fetch_halted); end
    RST = 1'b0;
    tick();  // IDLE cycle consumed
    total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL idle_to_fetch_ren got=%b exp=1", imemREN); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", ifid_valid); end
  endtask

  task automatic test_stream();
    tick();
    total++; if (ifid_instr !== 32'h2001_0005) begin bad++; $display("FAIL stream_instr got=%h exp=%h", ifid_instr, 32'h2001_0005); end
    total++; if (ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1) begin bad++; $display("FAIL stream_pc4_0 got=%h/%b exp=4/1", ifid_pc4, ifid_valid); end
    tick();
    total++; if (ifid_pc4 !== 32'h8) begin bad++; $display("FAIL stream_pc4_1 got=%h exp=8", ifid_pc4); end
    total++; if (imemaddr !== 32'h8) begin bad++; $display("FAIL stream_pc got=%h exp=8", imemaddr); end
  endtask

  task automatic test_stall();
    pc_en = 1'b0; ifid_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imemaddr !== 32'h8) begin bad++; $display("FAIL stall_pc cyc=%0d got=%h exp=8", i, imemaddr); end
      total++; if (ifid_pc4 !== 32'h8 || ifid_valid !== 1'b1 || ifid_instr !== 32'h2001_0005)
        begin bad++; $display("FAIL stall_hold cyc=%0d got=%h/%h/%b exp=20010005/8/1", i, ifid_instr, ifid_pc4, ifid_valid); end
    end
    pc_en = 1'b1; ifid_en = 1'b1;
    tick();
    total++; if (ifid_pc4 !== 32'hC) begin bad++; $display("FAIL stall_release_pc4 got=%h exp=c", ifid_pc4); end
    total++; if (imemaddr !== 32'hC) begin bad++; $display("FAIL stall_release_pc got=%h exp=c", imemaddr); end
  endtask

  task automatic test_redirect();
    imemload = 32'hDEAD_BEEF; redirect = 1'b1; redirect_pc = 32'h0000_0043; flush_ifid = 1'b1;
    tick();
    total++; if (imemaddr !== 32'h40) begin bad++; $display("FAIL redir_pc got=%h exp=40", imemaddr); end
    total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin bad++; $display("FAIL redir_bubble got=%h/%b exp=0/0", ifid_instr, ifid_valid); end
    redirect = 1'b0; flush_ifid = 1'b0; imemload = 32'h2001_0005;
    tick();
    total++; if (ifid_instr !== 32'h2001_0005 || ifid_pc4 !== 32'h44) begin bad++; $display("FAIL redir_next got=%h/%h exp=20010005/44", ifid_instr, ifid_pc4); end
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirect_pc = 32'h13; flush_ifid = 1'b1;
    tick();
    redirect = 1'b0; flush_ifid = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    total++; if (fetch_halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", fetch_halted); end
    total++; if (imemREN !== 1'b0 || ifid_valid !== 1'b0) begin bad++; $display("FAIL halt_ren_valid got=%b/%b exp=0/0", imemREN, ifid_valid); end
    total++; if (imemaddr !== 32'h10) begin bad++; $display("FAIL halt_pc got=%h exp=10", imemaddr); end
    for (int i = 0; i < 10; i++) tick();
    total++; if (imemaddr !== 32'h10 || fetch_halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%h/%b exp=10/1", imemaddr, fetch_halted); end
  endtask

  task automatic test_wrap_async();
    RST = 1'b1; #1;
    total++; if (fetch_halted !== 1'b0 || imemaddr !== 32'h0) begin bad++; $display("FAIL rst_clears_halt got=%b/%h exp=0/0", fetch_halted, imemaddr); end
    RST = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    total++; if (imemaddr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup got=%h exp=fffffffc", imemaddr); end
    redirect = 1'b0;
    tick();
    total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", imemaddr); end
    total++; if (ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc4 got=%h/%b exp=0/1", ifid_pc4, ifid_valid); end
    tick();
    #3 RST = 1'b1;
    #1;
    total++; if (imemaddr !== 32'h0 || ifid_valid !== 1'b0 || imemREN !== 1'b0)
      begin bad++; $display("FAIL async_rst got=%h/%b/%b exp=0/0/0", imemaddr, ifid_valid, imemREN); end
    RST = 1'b0;
    tick();
  endtask

`ifdef FETCH_BUF_EN
  task automatic test_fetch_buf();
    redirect = 1'b1; redirect_pc = 32'h14; pc_en = 1'b1; ifid_en = 1'b1;
    tick();
    redirect = 1'b0; ifid_en = 1'b0; pc_en = 1'b0; imemload = 32'hAC22_0004;
    tick();
    total++; if (imemaddr !== 32'h18 || imemREN !== 1'b0) begin bad++; $display("FAIL buf_capture got=%h/%b exp=18/0", imemaddr, imemREN); end
    imemload = 32'h1111_1111;
    tick();
    total++; if (imemaddr !== 32'h18 || ifid_valid !== 1'b0) begin bad++; $display("FAIL buf_wait got=%h/%b exp=18/0", imemaddr, ifid_valid); end
    ifid_en = 1'b1;
    tick();
    total++; if (ifid_instr !== 32'hAC22_0004 || ifid_pc4 !== 32'h18 || ifid_valid !== 1'b1)
      begin bad++; $display("FAIL buf_drain got=%h/%h/%b exp=ac220004/18/1", ifid_instr, ifid_pc4, ifid_valid); end
    total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL buf_resume_ren got=%b exp=1", imemREN); end
    pc_en = 1'b1;
    tick();
    total++; if (ifid_instr !== 32'h1111_1111 || ifid_pc4 !== 32'h1C || imemaddr !== 32'h1C)
      begin bad++; $display("FAIL buf_resume got=%h/%h/%h exp=11111111/1c/1c", ifid_instr, ifid_pc4, imemaddr); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap_async();
`ifdef FETCH_BUF_EN
    test_fetch_buf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
